// File: rtl/oec_pkg.sv
// Shared types and helpers for the over-exposure-correction window array loader.
package oec_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } load_state_e;

  function automatic int word_w(input int dw_in, input int ppw);
    return dw_in * ppw;
  endfunction

  // LSB of element (r,c) in the flattened array; c=0 is the oldest column.
  function automatic int elem_lsb(input int r, input int c, input int ncol, input int word);
    return (r * ncol + c) * word;
  endfunction

endpackage

// File: rtl/window_row_shift.sv
// One window row: NCOL-deep word shift register with a replace/data input mux.
module window_row_shift #(
  parameter int NCOL = 13,
  parameter int WORD = 40
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 rep_sel,
  input  logic [WORD-1:0]      rep_word,
  input  logic [WORD-1:0]      data_word,
  output logic [NCOL*WORD-1:0] row_out
);

  logic [WORD-1:0] new_word;

  assign new_word = rep_sel ? rep_word : data_word;

  // New word enters at the top column; everything moves one column toward index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_out <= '0;
    end else if (en) begin
      row_out <= {new_word, row_out[NCOL*WORD-1:WORD]};
    end
  end

endmodule

// File: rtl/window_array_loader.sv
// Loads an NROW x NCOL window array one column per accepted beat, replacing the
// top NREP rows with corrected words inside the REP_LO..REP_HI column range.
module window_array_loader
  import oec_pkg::*;
#(
  parameter int DW_IN         = 10,
  parameter int PPW           = 4,
  parameter int NROW          = 7,
  parameter int NCOL          = 13,
  parameter int NREP          = 3,
  parameter int REP_LO        = 6,
  parameter int REP_HI        = 12,
  parameter int ROW_CNT_WIDTH = 4,
  parameter int CW            = $clog2(NCOL + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [ROW_CNT_WIDTH-1:0]         row_cnt,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NROW*DW_IN*PPW-1:0]        data_in,
  input  logic [NREP*DW_IN*PPW-1:0]        rep_data,
  output logic                             busy,
  output logic                             done,
  output logic [CW-1:0]                    col_idx,
  output logic [NROW*NCOL*DW_IN*PPW-1:0]   array_out
);

  localparam int WORD = word_w(DW_IN, PPW);

  load_state_e              state;
  load_state_e              state_nxt;
  logic [ROW_CNT_WIDTH-1:0] row_q;
  logic                     beat;
  logic                     last_beat;
  logic                     in_rep_window;

  // Handshake: a beat transfers on a cycle where in_valid and in_ready are both
  // high; in_ready is high for the whole LOAD state and never in IDLE.
  assign busy          = (state == LOAD);
  assign in_ready      = busy;
  assign beat          = in_valid & in_ready;
  assign last_beat     = beat && (col_idx == CW'(NCOL - 1));
  assign in_rep_window = (col_idx >= CW'(REP_LO)) && (col_idx <= CW'(REP_HI));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q   <= '0;
      col_idx <= '0;
      done    <= 1'b0;
    end else begin
      done <= last_beat;
      if (state == IDLE && start) begin
        row_q   <= row_cnt;
        col_idx <= '0;
      end else if (beat) begin
        col_idx <= last_beat ? '0 : col_idx + CW'(1);
      end
    end
  end

  for (genvar r = 0; r < NROW; r++) begin : g_row
    logic            rep_sel;
    logic [WORD-1:0] rep_word;

    // Higher rows need a larger image row index before their data is replaced.
    if (r < NREP) begin : g_rep
      assign rep_sel  = in_rep_window && (row_q >= ROW_CNT_WIDTH'(NREP - r));
      assign rep_word = rep_data[r*WORD +: WORD];
    end else begin : g_norep
      assign rep_sel  = 1'b0;
      assign rep_word = '0;
    end

    window_row_shift #(
      .NCOL (NCOL),
      .WORD (WORD)
    ) u_row (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (beat),
      .rep_sel   (rep_sel),
      .rep_word  (rep_word),
      .data_word (data_in[r*WORD +: WORD]),
      .row_out   (array_out[elem_lsb(r, 0, NCOL, WORD) +: NCOL*WORD])
    );
  end

endmodule

// File: tb/tb_window_array_loader.sv
// Bench for window_array_loader: column-history model, directed loads, and a
// second instance with a smaller geometry.
module tb_window_array_loader;

  localparam int DW_IN = 10, PPW = 4, NROW = 7, NCOL = 13, NREP = 3;
  localparam int REP_LO = 6, REP_HI = 12, RCW = 4;
  localparam int WORD = DW_IN * PPW;
  localparam int CW   = $clog2(NCOL + 1);
  localparam int AW   = NROW * NCOL * WORD;

  localparam int S_NROW = 5, S_NCOL = 9, S_PPW = 2, S_NREP = 2, S_REP_LO = 3, S_REP_HI = 8;
  localparam int S_WORD = DW_IN * S_PPW;
  localparam int S_CW   = $clog2(S_NCOL + 1);
  localparam int S_AW   = S_NROW * S_NCOL * S_WORD;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                   start = 1'b0;
  logic [RCW-1:0]         row_cnt = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [NROW*WORD-1:0]   data_in = '0;
  logic [NREP*WORD-1:0]   rep_data = '0;
  logic                   busy;
  logic                   done;
  logic [CW-1:0]          col_idx;
  logic [AW-1:0]          array_out;

  logic                   s_start = 1'b0;
  logic [RCW-1:0]         s_row_cnt = '0;
  logic                   s_in_valid = 1'b0;
  logic                   s_in_ready;
  logic [S_NROW*S_WORD-1:0] s_data_in = '0;
  logic [S_NREP*S_WORD-1:0] s_rep_data = '0;
  logic                   s_busy;
  logic                   s_done;
  logic [S_CW-1:0]        s_col_idx;
  logic [S_AW-1:0]        s_array_out;

  window_array_loader dut (
    .clk (clk), .rst_n (rst_n), .start (start), .row_cnt (row_cnt),
    .in_valid (in_valid), .in_ready (in_ready), .data_in (data_in),
    .rep_data (rep_data), .busy (busy), .done (done), .col_idx (col_idx),
    .array_out (array_out)
  );

  window_array_loader #(
    .DW_IN (DW_IN), .PPW (S_PPW), .NROW (S_NROW), .NCOL (S_NCOL), .NREP (S_NREP),
    .REP_LO (S_REP_LO), .REP_HI (S_REP_HI), .ROW_CNT_WIDTH (RCW)
  ) dut_s (
    .clk (clk), .rst_n (rst_n), .start (s_start), .row_cnt (s_row_cnt),
    .in_valid (s_in_valid), .in_ready (s_in_ready), .data_in (s_data_in),
    .rep_data (s_rep_data), .busy (s_busy), .done (s_done), .col_idx (s_col_idx),
    .array_out (s_array_out)
  );

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // Model: queue of accepted columns (newest at back), window = last NCOL entries.
  logic [NROW*WORD-1:0] exp_q[$];
  bit                   m_busy = 1'b0;
  bit                   m_done = 1'b0;
  int                   m_cnt  = 0;
  logic [RCW-1:0]       m_rowq = '0;
  logic [NROW*WORD-1:0] m_col;
  bit                   m_rep;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_busy = 1'b0;
      m_done = 1'b0;
      m_cnt  = 0;
      m_rowq = '0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1;
          m_rowq = row_cnt;
          m_cnt  = 0;
        end
      end else if (in_valid) begin
        for (int r = 0; r < NROW; r++) begin
          m_rep = (r < NREP) && (int'(m_rowq) >= NREP - r) && (m_cnt >= REP_LO) && (m_cnt <= REP_HI);
          m_col[r*WORD +: WORD] = m_rep ? rep_data[r*WORD +: WORD] : data_in[r*WORD +: WORD];
        end
        exp_q.push_back(m_col);
        if (exp_q.size() > NCOL) void'(exp_q.pop_front());
        m_cnt++;
        if (m_cnt == NCOL) begin
          m_busy = 1'b0;
          m_cnt  = 0;
          m_done = 1'b1;
        end
      end
    end
  end

  function automatic logic [AW-1:0] model_array();
    logic [AW-1:0] e = '0;
    int n = exp_q.size();
    for (int c = 0; c < NCOL; c++) begin
      int idx = c - (NCOL - n);
      if (idx >= 0)
        for (int r = 0; r < NROW; r++)
          e[(r*NCOL+c)*WORD +: WORD] = exp_q[idx][r*WORD +: WORD];
    end
    return e;
  endfunction

  // Compare process: every cycle, shortly after the inactive edge.
  always @(negedge clk) begin
    logic [AW-1:0] e;
    bit reported;
    #1;
    chk("busy", busy, m_busy);
    chk("in_ready", in_ready, m_busy);
    chk("done", done, m_done);
    chk("col_idx", col_idx, m_cnt);
    if (done) done_seen++;
    e = model_array();
    checks++;
    if (array_out !== e) begin
      errors++;
      reported = 1'b0;
      for (int r = 0; r < NROW; r++)
        for (int c = 0; c < NCOL; c++)
          if (!reported && array_out[(r*NCOL+c)*WORD +: WORD] !== e[(r*NCOL+c)*WORD +: WORD]) begin
            reported = 1'b1;
            $display("FAIL array r%0d c%0d got %h exp %h", r, c,
                     array_out[(r*NCOL+c)*WORD +: WORD], e[(r*NCOL+c)*WORD +: WORD]);
          end
    end
  end

  function automatic logic [WORD-1:0] dword(input int base, input int r, input int c);
    return WORD'(base + r * 256 + c);
  endfunction

  function automatic logic [WORD-1:0] rword(input int base, input int r, input int c);
    return WORD'(32'hA0000 + base + r * 256 + c);
  endfunction

  // Driver: called on a negedge; returns on the negedge where done must be high.
  task automatic run_load(input int base, input logic [RCW-1:0] rc, input bit stall,
                          input int busy_start_at, input int exp_cycles, input string tag);
    int cyc = 0;
    start    = 1'b1;
    row_cnt  = rc;
    in_valid = 1'b0;
    @(negedge clk); cyc++;
    start = 1'b0;
    for (int c = 0; c < NCOL; c++) begin
      for (int r = 0; r < NROW; r++) data_in[r*WORD +: WORD] = dword(base, r, c);
      for (int r = 0; r < NREP; r++) rep_data[r*WORD +: WORD] = rword(base, r, c);
      in_valid = 1'b1;
      start    = (c == busy_start_at);
      @(negedge clk); cyc++;
      start = 1'b0;
      if (stall && (c == 3 || c == 8)) begin
        in_valid = 1'b0;
        repeat (3) begin @(negedge clk); cyc++; end
      end
    end
    in_valid = 1'b0;
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_latency"}, cyc, exp_cycles);
  endtask

  // Hand rule for the final array of a full load of the default instance.
  task automatic pin_array(input string tag, input int base, input int rc);
    bit rep;
    for (int r = 0; r < NROW; r++)
      for (int c = 0; c < NCOL; c++) begin
        rep = (r < NREP) && (rc >= NREP - r) && (c >= REP_LO) && (c <= REP_HI);
        chk($sformatf("%s_r%0d_c%0d", tag, r, c), array_out[(r*NCOL+c)*WORD +: WORD],
            rep ? rword(base, r, c) : dword(base, r, c));
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_col_idx", col_idx, 0);
    chk("rst_array_nz", |array_out, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // in_valid while idle is ignored
    data_in  = {NROW{40'h12345}};
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle_array_nz", |array_out, 1'b0);

    run_load(0, 4'd0, 1'b0, -1, 14, "basic");
    chk("basic_e2_5", array_out[(2*NCOL+5)*WORD +: WORD], 40'h0205);
    chk("basic_e0_12", array_out[(0*NCOL+12)*WORD +: WORD], 40'h000C);
    pin_array("basic", 0, 0);
    repeat (2) @(negedge clk);

    run_load(0, 4'd2, 1'b0, -1, 14, "rep2");
    chk("rep2_e1_6", array_out[(1*NCOL+6)*WORD +: WORD], 40'hA0106);
    chk("rep2_e0_6", array_out[(0*NCOL+6)*WORD +: WORD], 40'h00006);
    pin_array("rep2", 0, 2);
    repeat (2) @(negedge clk);

    run_load(0, 4'd3, 1'b0, -1, 14, "rep3");
    chk("rep3_e0_12", array_out[(0*NCOL+12)*WORD +: WORD], 40'hA000C);
    pin_array("rep3", 0, 3);
    repeat (2) @(negedge clk);

    run_load(0, 4'd3, 1'b1, -1, 20, "stall");
    pin_array("stall", 0, 3);
    repeat (2) @(negedge clk);

    done_seen = 0;
    run_load(32'h2000, 4'd0, 1'b0, 7, 14, "busystart");
    repeat (3) @(negedge clk);
    chk("busystart_done_count", done_seen, 1);
    chk("busystart_idle", busy, 1'b0);
    pin_array("busystart", 32'h2000, 0);

    run_load(32'h3000, 4'd0, 1'b0, -1, 14, "b2b_first");
    run_load(32'h4000, 4'd1, 1'b0, -1, 14, "b2b_second");
    chk("b2b_e2_6", array_out[(2*NCOL+6)*WORD +: WORD], 40'hA4206);
    pin_array("b2b", 32'h4000, 1);
    repeat (2) @(negedge clk);

    // reset in the middle of a load
    start = 1'b1; row_cnt = 4'd3;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      for (int r = 0; r < NROW; r++) data_in[r*WORD +: WORD] = dword(32'h5000, r, c);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("midrst_col_idx_before", col_idx, 5);
    rst_n = 1'b0;
    #2;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_col_idx", col_idx, 0);
    chk("midrst_array_nz", |array_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // smaller geometry: only row 1 replaced, columns 3..8
    begin
      int cyc = 0;
      s_start = 1'b1; s_row_cnt = 4'd1;
      @(negedge clk); cyc++;
      s_start = 1'b0;
      for (int c = 0; c < S_NCOL; c++) begin
        for (int r = 0; r < S_NROW; r++) s_data_in[r*S_WORD +: S_WORD] = S_WORD'(r * 256 + c);
        for (int r = 0; r < S_NREP; r++) s_rep_data[r*S_WORD +: S_WORD] = S_WORD'(32'hA0000 + r * 256 + c);
        s_in_valid = 1'b1;
        @(negedge clk); cyc++;
      end
      s_in_valid = 1'b0;
      chk("sweep_done", s_done, 1'b1);
      chk("sweep_latency", cyc, 10);
      for (int r = 0; r < S_NROW; r++)
        for (int c = 0; c < S_NCOL; c++)
          chk($sformatf("sweep_r%0d_c%0d", r, c), s_array_out[(r*S_NCOL+c)*S_WORD +: S_WORD],
              (r == 1 && c >= 3) ? S_WORD'(32'hA0000 + 256 + c) : S_WORD'(r * 256 + c));
      @(negedge clk);
      chk("sweep_done_clear", s_done, 1'b0);
      chk("sweep_idle", s_busy, 1'b0);
      chk("sweep_ready", s_in_ready, 1'b0);
      chk("sweep_col_idx", s_col_idx, 0);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_array_loader.md
Name: window_array_loader

Overview:
- Parametrised loader for the over-exposure-correction window array: fills an NROW x NCOL array of packed multi-pixel words by shifting one column per accepted input beat.
- Generalises the fixed 7x13, 4-pixel loader. Adds:
  - configurable geometry;
  - valid/ready input handshake with stalls;
  - start/busy/done control with an internal column counter;
  - parametrised per-row replacement of the top NREP rows with corrected (IMO) data.
- Sits between the line buffers/IMO correction stage and the window compute stage.

Parameters:
DW_IN, 10, bits per pixel
PPW, 4, pixels per word; WORD = DW_IN*PPW
NROW, 7, rows in the window array
NCOL, 13, columns (words) per row
NREP, 3, top rows eligible for replacement (NREP < NROW)
REP_LO, 6, first column index (0-based load index) where replacement applies
REP_HI, 12, last column index where replacement applies (REP_LO <= REP_HI < NCOL)
ROW_CNT_WIDTH, 4, width of row_cnt
CW, $clog2(NCOL+1), load counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request a load of NCOL columns; one-cycle pulse
row_cnt  in  ROW_CNT_WIDTH  current image row index; sampled at start
in_valid  in  1  input column beat valid
in_ready  out  1  loader accepts beat (= busy)
data_in  in  NROW*WORD  one word per row; row r at [r*WORD +: WORD]
rep_data  in  NREP*WORD  replacement word per top row; row r at [r*WORD +: WORD]
busy  out  1  load in progress
done  out  1  one-cycle pulse after the last column is accepted
col_idx  out  CW  number of columns accepted so far in the current load
array_out  out  NROW*NCOL*WORD  element (r,c) at [(r*NCOL+c)*WORD +: WORD]; c=0 is oldest

Behaviour:
- Reset (async, rst_n=0):
  - array_out = 0, busy = 0, done = 0, col_idx = 0, in_ready = 0.
  - Row threshold register cleared.
- States: IDLE, LOAD.
  - IDLE: start=1 -> LOAD next cycle; latch row_cnt into row_q; col_idx <= 0. No beat is accepted in the start cycle.
  - LOAD: busy=1, in_ready=1. Beat accepted when in_valid & in_ready. With no beat, the array and col_idx hold (stall).
- Per accepted beat, for every row r:
  - columns 0..NCOL-2 take columns 1..NCOL-1 (shift toward index 0);
  - column NCOL-1 takes the new word.
- New word source for row r:
  - rep_data word r when r < NREP, row_q >= NREP-r, and REP_LO <= col_idx <= REP_HI;
  - otherwise data_in word r.
  - Row threshold example for NREP=3: row0 needs row_q>=3, row1 >=2, row2 >=1.
- Load completion:
  - col_idx increments per accepted beat.
  - When the beat with col_idx = NCOL-1 is accepted: done=1 for the next cycle, return to IDLE, col_idx <= 0.
  - The array holds its contents in IDLE.
- start while busy is ignored (no restart, no error).
- start in the same cycle done is asserted is legal: back-to-back loads; the first beat of the new load is accepted the cycle after.
- in_valid in IDLE is ignored.
- Latency: first beat accepted earliest 1 cycle after start. The final column is visible on array_out the cycle after its beat; done is asserted in that same cycle. Minimum load time is NCOL+1 cycles.
- Reset mid-LOAD aborts: all state returns to reset values immediately.
- All arithmetic is unsigned; row_q compare is at ROW_CNT_WIDTH bits.

Decomposition:
- Shared package oec_pkg holds:
  - WORD width function;
  - loader state enum (IDLE/LOAD);
  - array index helper elem_lsb(r,c).
- One natural sub-module: window_row_shift, a single row's NCOL-deep shift register with enable and a 2:1 input mux (replace select, rep word, data word).
- The top instantiates NROW copies via generate, plus the FSM/counter and per-row select logic.

Test Plan:
- Reset/idle: assert rst_n=0 mid-load at col_idx=5 -> array_out=0, busy=0, done=0 next sample; in_valid pulses while idle leave array_out=0.
- Basic fill, row_cnt=0, data_in word r = {r,c} per beat, in_valid held high:
  - done pulses exactly 14 cycles after start;
  - element (r,c) = {r,c} for all 7x13;
  - no replacement occurs.
- Replacement, row_cnt=2, rep_data distinct pattern:
  - rows 1 and 2 hold rep words at columns 6..12 and data_in at 0..5;
  - row 0 is all data_in;
  - rows 3..6 are all data_in.
  - Repeat with row_cnt=3: row 0 is also replaced at columns 6..12.
- Stall: deassert in_valid for 3 cycles after beats 4 and 9 -> col_idx holds; done arrives 6 cycles later than unstalled; final contents are identical to the unstalled run.
- Control: start pulse while busy at col_idx=7 is ignored (done only once, after 13 beats); start coincident with done starts a second load whose contents fully replace the first after 13 further beats.
- Parameter sweep: NROW=5, NCOL=9, PPW=2, NREP=2, REP_LO=3, REP_HI=8, row_cnt=1 -> only row 1 is replaced at columns 3..8; done after 9 beats.
